// File: rtl/hamming74_link_if.sv
// Hamming(7,4) link bundle: nibble-side TX handshake, serial TX/RX pins,
// decoded RX results and the error counter with its clear.
//   master : user logic / pin driver side (drives tx_data, tx_valid,
//            rx_sd, rx_frame, err_clr)
//   slave  : the link controller
interface hamming74_link_if #(
  parameter int ERR_CNT_W = 8
);
  logic [3:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_sd;
  logic                 tx_frame;
  logic                 rx_sd;
  logic                 rx_frame;
  logic [3:0]           rx_data;
  logic [2:0]           rx_syndrome;
  logic                 rx_corrected;
  logic                 rx_valid;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clr;

  modport master (
    output tx_data, tx_valid, rx_sd, rx_frame, err_clr,
    input  tx_ready, tx_sd, tx_frame, rx_data, rx_syndrome,
           rx_corrected, rx_valid, err_count
  );

  modport slave (
    input  tx_data, tx_valid, rx_sd, rx_frame, err_clr,
    output tx_ready, tx_sd, tx_frame, rx_data, rx_syndrome,
           rx_corrected, rx_valid, err_count
  );
endinterface

// File: rtl/hamming74_link_ctrl.sv
// Hamming(7,4) serial link controller.
// TX: accepts a nibble on tx_valid/tx_ready, encodes it and shifts the
//     7-bit codeword out LSB-first on tx_sd while tx_frame is high.
//     Back-to-back nibbles produce a gapless frame stream.
// RX: collects framed bits from rx_sd into 7-bit words, corrects single-bit
//     errors and reports rx_data/rx_syndrome/rx_corrected with an rx_valid
//     pulse; err_count saturates and counts words with a nonzero syndrome.
// Ports: clk, rst_n (async active-low), link (hamming74_link_if.slave).
module hamming74_link_ctrl #(
  parameter int ERR_CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  hamming74_link_if.slave  link
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // ---------------------------------------------------------------- TX
  logic [0:0] tx_state;
  logic [2:0] tx_cnt;
  logic [5:0] tx_shreg;   // codeword bits still to be sent after tx_sd
  logic       tx_sd_q;
  logic [6:0] tx_cw;
  logic       tx_last;
  logic       tx_load;

  assign tx_cw = {link.tx_data[3],
                  link.tx_data[2],
                  link.tx_data[1],
                  link.tx_data[1] ^ link.tx_data[2] ^ link.tx_data[3],
                  link.tx_data[0],
                  link.tx_data[0] ^ link.tx_data[2] ^ link.tx_data[3],
                  link.tx_data[0] ^ link.tx_data[1] ^ link.tx_data[3]};

  // The last bit of a frame is on the wire: accept the next nibble now so
  // its cw[0] follows with no gap.
  assign tx_last       = (tx_state == SHIFT) && (tx_cnt == 3'd6);
  assign link.tx_ready = (tx_state == IDLE) || tx_last;
  assign tx_load       = link.tx_valid && link.tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= 3'd0;
      tx_shreg <= 6'd0;
      tx_sd_q  <= 1'b0;
    end else if (tx_load) begin
      tx_state <= SHIFT;
      tx_cnt   <= 3'd0;
      tx_shreg <= tx_cw[6:1];
      tx_sd_q  <= tx_cw[0];
    end else if (tx_state == SHIFT) begin
      if (tx_last) begin
        tx_state <= IDLE;
        tx_cnt   <= 3'd0;
        tx_sd_q  <= 1'b0;
      end else begin
        tx_cnt   <= tx_cnt + 3'd1;
        tx_sd_q  <= tx_shreg[0];
        tx_shreg <= {1'b0, tx_shreg[5:1]};
      end
    end
  end

  assign link.tx_sd    = tx_sd_q;
  assign link.tx_frame = (tx_state == SHIFT);

  // ---------------------------------------------------------------- RX
  logic [2:0]           rx_cnt;
  logic [5:0]           rx_shreg;   // r0..r5 of the word being collected
  logic [6:0]           rx_word;
  logic [2:0]           rx_syn;
  logic [3:0]           rx_fixed;
  logic                 rx_done;
  logic                 err_inc;
  logic [3:0]           rx_data_q;
  logic [2:0]           rx_syn_q;
  logic                 rx_corr_q;
  logic                 rx_valid_q;
  logic [ERR_CNT_W-1:0] err_q;

  // r6 is taken straight from the pin so the word decodes on its last bit.
  assign rx_word = {link.rx_sd, rx_shreg};
  assign rx_done = link.rx_frame && (rx_cnt == 3'd6);

  assign rx_syn = {rx_word[0] ^ rx_word[2] ^ rx_word[4] ^ rx_word[6],
                   rx_word[1] ^ rx_word[2] ^ rx_word[5] ^ rx_word[6],
                   rx_word[3] ^ rx_word[4] ^ rx_word[5] ^ rx_word[6]};

  // NOTE: default assignment first keeps this block purely combinational
  // (no latch) for syndromes that leave the data untouched.
  always_comb begin
    rx_fixed = {rx_word[6], rx_word[5], rx_word[4], rx_word[2]};
    case (rx_syn)
      3'b110:  rx_fixed[0] = ~rx_fixed[0];
      3'b101:  rx_fixed[1] = ~rx_fixed[1];
      3'b011:  rx_fixed[2] = ~rx_fixed[2];
      3'b111:  rx_fixed[3] = ~rx_fixed[3];
      default: ;  // error (if any) sits in a parity bit
    endcase
  end

  assign err_inc = rx_done && (rx_syn != 3'b000);

  // NOTE: the collection register is deliberately not reset; every position
  // is rewritten before a word can complete, so stale bits are never used.
  always_ff @(posedge clk) begin
    if (link.rx_frame && (rx_cnt != 3'd6)) begin
      rx_shreg[rx_cnt] <= link.rx_sd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt     <= 3'd0;
      rx_data_q  <= 4'd0;
      rx_syn_q   <= 3'd0;
      rx_corr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_done;
      if (!link.rx_frame) begin
        rx_cnt <= 3'd0;             // drop any partial word
      end else if (rx_done) begin
        rx_cnt    <= 3'd0;
        rx_data_q <= rx_fixed;
        rx_syn_q  <= rx_syn;
        rx_corr_q <= (rx_syn != 3'b000);
      end else begin
        rx_cnt <= rx_cnt + 3'd1;
      end
    end
  end

  // Clear wins over the old count but not over a simultaneous new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (link.err_clr) begin
      err_q <= {{(ERR_CNT_W-1){1'b0}}, err_inc};
    end else if (err_inc && !(&err_q)) begin
      err_q <= err_q + ERR_CNT_W'(1);
    end
  end

  assign link.rx_data      = rx_data_q;
  assign link.rx_syndrome  = rx_syn_q;
  assign link.rx_corrected = rx_corr_q;
  assign link.rx_valid     = rx_valid_q;
  assign link.err_count    = err_q;

endmodule

// File: tb/tb_hamming74_link_ctrl.sv
// Bench for hamming74_link_ctrl: two instances (8-bit and 2-bit error
// counters) share one stimulus; a queue-based reference model is compared
// against both on every falling edge, plus literal checks from hand decoding.
module tb_hamming74_link_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] tx_data_d  = '0;
  logic       tx_valid_d = 1'b0;
  logic       rx_sd_d    = 1'b0;
  logic       rx_frame_d = 1'b0;
  logic       err_clr_d  = 1'b0;
  logic       loop       = 1'b0;

  hamming74_link_if #(.ERR_CNT_W(8)) i8 ();
  hamming74_link_if #(.ERR_CNT_W(2)) i2 ();

  assign i8.tx_data  = tx_data_d;
  assign i8.tx_valid = tx_valid_d;
  assign i8.err_clr  = err_clr_d;
  assign i8.rx_sd    = loop ? i8.tx_sd    : rx_sd_d;
  assign i8.rx_frame = loop ? i8.tx_frame : rx_frame_d;
  assign i2.tx_data  = tx_data_d;
  assign i2.tx_valid = tx_valid_d;
  assign i2.err_clr  = err_clr_d;
  assign i2.rx_sd    = loop ? i2.tx_sd    : rx_sd_d;
  assign i2.rx_frame = loop ? i2.tx_frame : rx_frame_d;

  hamming74_link_ctrl #(.ERR_CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .link(i8));
  hamming74_link_ctrl #(.ERR_CNT_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .link(i2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ------------------------------------------------ reference model
  // Classic positional Hamming: codeword position p (1..7) = cw[p-1];
  // parity at p=1,2,4 covers every other position with that bit of p set.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] cw;
    logic       p;
    cw    = '0;
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    for (int k = 1; k <= 4; k = k * 2) begin
      p = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (((pos & k) != 0) && (pos != k)) p ^= cw[pos-1];
      cw[k-1] = p;
    end
    return cw;
  endfunction

  // Syndrome = XOR of the positions of set bits; data = nearest codeword.
  function automatic void dec(input logic [6:0] r, output logic [3:0] d,
                              output logic [2:0] syn);
    int s;
    s = 0;
    for (int pos = 1; pos <= 7; pos++) if (r[pos-1]) s ^= pos;
    syn = {s[0], s[1], s[2]};
    d = '0;
    for (int c = 0; c < 16; c++)
      if ($countones(enc(4'(c)) ^ r) <= 1) d = 4'(c);
  endfunction

  function automatic int sat_cnt(input int cur, input bit inc, input bit clr, input int max);
    if (clr) return inc ? 1 : 0;
    if (inc && cur < max) return cur + 1;
    return cur;
  endfunction

  bit         tx_q[$];       // bits still to appear on tx_sd, head = now
  bit         rx_q[$];
  logic [3:0] m_data;
  logic [2:0] m_syn;
  bit         m_corr, m_valid;
  int         m_err8, m_err2;

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy, fr, sd, inc;
    logic [6:0] w;
    logic [3:0] d;
    logic [2:0] s;
    if (!rst_n) begin
      tx_q.delete();
      rx_q.delete();
      m_data = '0; m_syn = '0; m_corr = 0; m_valid = 0;
      m_err8 = 0;  m_err2 = 0;
    end else begin
      rdy = (tx_q.size() <= 1);
      fr  = loop ? (tx_q.size() > 0) : rx_frame_d;
      sd  = loop ? ((tx_q.size() > 0) ? tx_q[0] : 1'b0) : rx_sd_d;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_valid_d && rdy) begin
        w = enc(tx_data_d);
        for (int i = 0; i < 7; i++) tx_q.push_back(w[i]);
      end
      m_valid = 0;
      inc     = 0;
      if (fr) begin
        rx_q.push_back(sd);
        if (rx_q.size() == 7) begin
          for (int i = 0; i < 7; i++) w[i] = rx_q[i];
          dec(w, d, s);
          m_data = d; m_syn = s; m_corr = (s != 0); m_valid = 1;
          inc = (s != 0);
          rx_q.delete();
        end
      end else begin
        rx_q.delete();
      end
      m_err8 = sat_cnt(m_err8, inc, err_clr_d, 255);
      m_err2 = sat_cnt(m_err2, inc, err_clr_d, 3);
    end
  end

  // ------------------------------------------------ per-cycle compare
  bit cmp_en = 0;

  task automatic cmp_dut(input string tag, input logic rdy, input logic sd,
                         input logic fr, input logic vld, input logic [3:0] dat,
                         input logic [2:0] syn, input logic corr,
                         input logic [7:0] err, input int exp_err);
    check({tag, ".tx_ready"}, rdy, tx_q.size() <= 1);
    check({tag, ".tx_frame"}, fr, tx_q.size() > 0);
    check({tag, ".tx_sd"}, sd, (tx_q.size() > 0) ? tx_q[0] : 1'b0);
    check({tag, ".rx_valid"}, vld, m_valid);
    check({tag, ".rx_data"}, dat, m_data);
    check({tag, ".rx_syndrome"}, syn, m_syn);
    check({tag, ".rx_corrected"}, corr, m_corr);
    check({tag, ".err_count"}, err, exp_err);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_dut("d8", i8.tx_ready, i8.tx_sd, i8.tx_frame, i8.rx_valid, i8.rx_data,
              i8.rx_syndrome, i8.rx_corrected, i8.err_count, m_err8);
      cmp_dut("d2", i2.tx_ready, i2.tx_sd, i2.tx_frame, i2.rx_valid, i2.rx_data,
              i2.rx_syndrome, i2.rx_corrected, {6'd0, i2.err_count}, m_err2);
    end
  end

  // ------------------------------------------------ monitor
  logic [6:0] mon_q[$];      // {syndrome, data} of each rx_valid pulse
  int run_len = 0;
  int max_run = 0;

  always @(negedge clk) begin
    if (i8.rx_valid) mon_q.push_back({i8.rx_syndrome, i8.rx_data});
    if (i8.tx_frame) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  // ------------------------------------------------ stimulus helpers
  task automatic tx_send(input logic [3:0] nib);
    int n;
    n = 0;
    tx_data_d  = nib;
    tx_valid_d = 1'b1;
    while (!i8.tx_ready && n < 20) begin
      step();
      n++;
    end
    check("tx_send_ready", i8.tx_ready, 1'b1);
    step();
    tx_valid_d = 1'b0;
  endtask

  // Sends one nibble from idle and checks the serial frame against a literal.
  task automatic tx_frame_check(input logic [3:0] nib, input logic [6:0] exp_cw);
    logic [6:0] got;
    got = '0;
    tx_data_d  = nib;
    tx_valid_d = 1'b1;
    step();
    tx_valid_d = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("txf.frame", i8.tx_frame, 1'b1);
      check("txf.ready", i8.tx_ready, (i == 6));
      got[i] = i8.tx_sd;
      step();
    end
    check("txf.codeword", got, exp_cw);
    check("txf.idle_frame", i8.tx_frame, 1'b0);
    check("txf.idle_ready", i8.tx_ready, 1'b1);
  endtask

  task automatic send_rx(input logic [6:0] w, input int nbits, input bit clr_last);
    for (int i = 0; i < nbits; i++) begin
      rx_frame_d = 1'b1;
      rx_sd_d    = w[i];
      err_clr_d  = clr_last && (i == nbits - 1);
      step();
    end
    rx_frame_d = 1'b0;
    err_clr_d  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".tx_sd"}, i8.tx_sd, 1'b0);
    check({tag, ".tx_frame"}, i8.tx_frame, 1'b0);
    check({tag, ".tx_ready"}, i8.tx_ready, 1'b1);
    check({tag, ".rx_data"}, i8.rx_data, 4'd0);
    check({tag, ".rx_syndrome"}, i8.rx_syndrome, 3'd0);
    check({tag, ".rx_corrected"}, i8.rx_corrected, 1'b0);
    check({tag, ".rx_valid"}, i8.rx_valid, 1'b0);
    check({tag, ".err_count"}, i8.err_count, 8'd0);
    check({tag, ".err_count2"}, i2.err_count, 2'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------ main sequence
  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    step();
    step();
    rst_n  = 1'b1;
    cmp_en = 1;
    step();

    // Single nibble 1011 -> 7'h55.
    tx_frame_check(4'b1011, 7'h55);

    // Loopback, four back-to-back nibbles.
    mon_q.delete();
    max_run = 0;
    loop    = 1'b1;
    tx_send(4'h0);
    tx_send(4'hF);
    tx_send(4'hA);
    tx_send(4'h5);
    repeat (12) step();
    loop = 1'b0;
    check("loop.frame_run", max_run, 28);
    check("loop.pulses", mon_q.size(), 4);
    if (mon_q.size() == 4) begin
      check("loop.w0", mon_q[0], {3'd0, 4'h0});
      check("loop.w1", mon_q[1], {3'd0, 4'hF});
      check("loop.w2", mon_q[2], {3'd0, 4'hA});
      check("loop.w3", mon_q[3], {3'd0, 4'h5});
    end
    check("loop.err", i8.err_count, 8'd0);

    // Single-bit errors.
    send_rx(7'h45, 7, 0);
    check("e45.valid", i8.rx_valid, 1'b1);
    check("e45.data", i8.rx_data, 4'b1011);
    check("e45.syn", i8.rx_syndrome, 3'b101);
    check("e45.corr", i8.rx_corrected, 1'b1);
    check("e45.err", i8.err_count, 8'd1);
    send_rx(7'h54, 7, 0);
    check("e54.data", i8.rx_data, 4'b1011);
    check("e54.syn", i8.rx_syndrome, 3'b100);
    check("e54.err", i8.err_count, 8'd2);
    step();
    check("e54.pulse_gone", i8.rx_valid, 1'b0);
    check("e54.hold", i8.rx_data, 4'b1011);

    // Partial word discarded, then a full word.
    mon_q.delete();
    send_rx(7'h55, 4, 0);
    step();
    send_rx(7'h55, 7, 0);
    step();
    check("part.pulses", mon_q.size(), 1);
    if (mon_q.size() == 1) check("part.word", mon_q[0], {3'd0, 4'b1011});
    check("part.err", i8.err_count, 8'd2);

    // Saturation and clear behaviour.
    err_clr_d = 1'b1;
    step();
    err_clr_d = 1'b0;
    check("clr0.err8", i8.err_count, 8'd0);
    repeat (5) send_rx(7'h45, 7, 0);
    check("sat.err2", i2.err_count, 2'd3);
    check("sat.err8", i8.err_count, 8'd5);
    send_rx(7'h45, 7, 1);
    check("clrinc.err2", i2.err_count, 2'd1);
    check("clrinc.err8", i8.err_count, 8'd1);
    err_clr_d = 1'b1;
    step();
    err_clr_d = 1'b0;
    check("clr.err2", i2.err_count, 2'd0);
    check("clr.err8", i8.err_count, 8'd0);

    // Reset mid-word in both directions.
    send_rx(7'h45, 7, 0);  // nonzero state to observe the reset
    tx_data_d  = 4'b1011;
    tx_valid_d = 1'b1;
    rx_frame_d = 1'b1;
    rx_sd_d    = 1'b1;
    step();
    tx_valid_d = 1'b0;
    rx_sd_d    = 1'b0;
    step();
    rx_sd_d = 1'b1;
    step();
    rx_sd_d = 1'b0;
    step();
    check("mid.tx_frame", i8.tx_frame, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    rx_frame_d = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    mon_q.delete();
    send_rx(7'h55, 7, 0);
    check("post.valid", i8.rx_valid, 1'b1);
    check("post.data", i8.rx_data, 4'b1011);
    check("post.syn", i8.rx_syndrome, 3'b000);
    step();
    tx_frame_check(4'b1011, 7'h55);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) loop = 1'($urandom_range(0, 1));
      tx_valid_d = 1'($urandom_range(0, 1));
      tx_data_d  = 4'($urandom);
      rx_frame_d = ($urandom_range(0, 9) != 0);
      rx_sd_d    = 1'($urandom);
      err_clr_d  = ($urandom_range(0, 19) == 0);
      if (c == 1000) begin
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end
    loop       = 1'b0;
    tx_valid_d = 1'b0;
    rx_frame_d = 1'b0;
    err_clr_d  = 1'b0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hamming74_link_ctrl.md
# hamming74_link_ctrl

Serial link controller for the Hamming(7,4) code. On transmit it accepts 4-bit nibbles through a valid/ready handshake, encodes each one and shifts the 7-bit codeword out LSB-first under a frame strobe. On receive it deserialises framed 7-bit codewords, corrects single-bit errors and reports data, syndrome and a saturating error count. It sits between the chip I/O pins and the nibble-level user logic, and it sequences the encoder/decoder datapath.

## Interface
- `ERR_CNT_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `tx_data`  in  4  nibble to send; bit 0 is d0.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  controller can accept a nibble this cycle.
- `tx_sd`  out  1  serial codeword bit, registered.
- `tx_frame`  out  1  high while `tx_sd` carries a codeword bit, registered.
- `rx_sd`  in  1  serial received bit.
- `rx_frame`  in  1  `rx_sd` is valid this cycle.
- `rx_data`  out  4  corrected nibble.
- `rx_syndrome`  out  3  syndrome {A,B,C} of the last received word.
- `rx_corrected`  out  1  the last word had a nonzero syndrome.
- `rx_valid`  out  1  one-cycle pulse when new `rx_*` values are available.
- `err_count`  out  `ERR_CNT_W`  saturating count of words received with a nonzero syndrome.
- `err_clr`  in  1  synchronous clear of `err_count`.

## Operation
- Codeword layout:
  - cw[0] = d0^d1^d3
  - cw[1] = d0^d2^d3
  - cw[2] = d0
  - cw[3] = d1^d2^d3
  - cw[4] = d1
  - cw[5] = d2
  - cw[6] = d3
- Syndrome:
  - A = r0^r2^r4^r6
  - B = r1^r2^r5^r6
  - C = r3^r4^r5^r6
- Correction by syndrome:
  - 110 flips r2 (d0); 101 flips r4 (d1); 011 flips r5 (d2); 111 flips r6 (d3).
  - 000, 001, 010 and 100 leave the data as is (the error, if any, is in a parity bit).
  - `rx_data` = {r6, r5, r4, r2} after correction.
- TX state machine, states IDLE and SHIFT:
  - IDLE: `tx_ready`=1. When `tx_valid`&`tx_ready`, load the encoded codeword into a 7-bit shift register, set the bit counter to 0 and go to SHIFT.
  - SHIFT: `tx_frame`=1 and `tx_sd`=cw[cnt], LSB first; cnt increments every cycle.
  - At cnt=6, `tx_ready`=1. If a handshake happens then, load the new codeword and stay in SHIFT with cnt=0 (back-to-back, no gap). Otherwise go to IDLE.
  - `tx_ready` is 0 in SHIFT whenever cnt is 0 to 5.
  - `tx_sd`=0 whenever `tx_frame`=0.
- RX deserialiser:
  - Each cycle with `rx_frame`=1 shifts `rx_sd` in at position cnt (first bit is r0), then cnt increments.
  - After the 7th bit, the word is decoded, cnt returns to 0, and any further framed bits start a new word (continuous frames are allowed).
  - If `rx_frame`=0 while cnt is 1 to 6, the partial word is discarded: cnt goes to 0, no `rx_valid` pulse, `err_count` unchanged.
  - There is no RX backpressure. `rx_data`, `rx_syndrome` and `rx_corrected` hold their values until the next completed word.
- Error counter:
  - Increments by 1 for each completed word with a nonzero syndrome.
  - Saturates at all-ones.
  - If `err_clr` and an increment occur in the same cycle, the result is 1.
  - `err_clr` alone sets the counter to 0.
- Reset: `rst_n` low at any time, including mid-word, aborts both directions immediately. TX returns to IDLE and the RX partial word is discarded.

## Timing
- Reset values:
  - `tx_sd`=0, `tx_frame`=0, `tx_ready`=1 (state IDLE).
  - `rx_data`=0, `rx_syndrome`=0, `rx_corrected`=0, `rx_valid`=0, `err_count`=0.
- TX latency: a handshake at edge E puts cw[0] on `tx_sd`/`tx_frame` in the cycle after E. cw[6] appears 6 cycles later.
- TX throughput: one codeword per 7 cycles with continuous `tx_valid`; `tx_frame` stays high with no gap.
- RX latency: if r6 is sampled at edge E, then `rx_valid` and the new `rx_*` values are visible in the cycle after E (registered outputs).
- `err_count` updates at the same edge that raises `rx_valid`.

## Test plan
- Reset then `tx_data`=4'b1011 with `tx_valid` for one cycle: 7 cycles with `tx_frame`=1 and `tx_sd` sequence 1,0,1,0,1,0,1 (cw=7'h55); `tx_ready` low for cycles 1-6 of the frame; then back to IDLE.
- Loopback `tx_sd`→`rx_sd` and `tx_frame`→`rx_frame`, with nibbles 0, 4'hF, 4'hA, 4'h5 sent back-to-back: 28 contiguous `tx_frame` cycles; four `rx_valid` pulses return the same nibbles with `rx_syndrome`=0; `err_count`=0.
- RX codeword 7'h45 (bit 4 flipped from 7'h55): `rx_data`=4'b1011, `rx_syndrome`=3'b101, `rx_corrected`=1, `err_count`=1. Then RX 7'h54 (bit 0 flipped): `rx_data`=4'b1011, `rx_syndrome`=3'b100, `err_count`=2.
- `rx_frame` dropped after 4 bits, then a full 7'h55: no pulse for the partial word; exactly one `rx_valid` with data 4'b1011.
- `ERR_CNT_W`=2, five erroneous words: `err_count` saturates at 3. Then `err_clr` in the same cycle as another erroneous word: `err_count`=1. Then `err_clr` alone: 0.
- `rst_n` pulsed low at TX bit 3 and RX bit 3: all outputs return to their reset values asynchronously. The next full RX word decodes correctly and the next TX handshake starts at cw[0].
